midi_tx_encoder: RTL and testbench
==================================

Name: midi_tx_encoder

Overview:
- MIDI output path for the synthesizer: accepts whole MIDI messages (status plus up to two data bytes) over a valid/ready handshake.
- Derives the message length from the status byte and serialises the bytes as standard MIDI UART frames on midi_txd: 31250 baud, 8N1, LSB first, idle high.
- Counterpart of the synth_controller MIDI receive path. Sources are CPU/socmidi loopback or patch dump logic.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 31250, serial bit rate.
- BIT_CNT_W, 16, width of the baud divider counter; must hold CLK_HZ/BAUD-1.

Ports:
- CLOCK_50  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- msg_valid  input  1  message on msg_status/msg_data1/msg_data2 is valid.
- msg_ready  output  1  block can accept a message this cycle.
- msg_status  input  8  MIDI status byte.
- msg_data1  input  8  first data byte; bit 7 is ignored and transmitted as 0.
- msg_data2  input  8  second data byte; bit 7 is ignored and transmitted as 0.
- midi_txd  output  1  serial MIDI out, idle high.
- busy  output  1  a message is being transmitted.
- byte_done  output  1  one-cycle pulse at the end of each stop bit.
- status_err  output  1  one-cycle pulse when an offered status has bit7=0.

Behaviour:
- Reset values: midi_txd=1, msg_ready=1, busy=0, byte_done=0, status_err=0. Counters, state and running-status register are cleared.
- Reset asserted mid-frame forces midi_txd high immediately (asynchronous) and aborts the message.
- Bit period: DIV = CLK_HZ/BAUD clocks (1600 at the defaults). The divider counts 0..DIV-1.
- Accept rule: a message is accepted on a rising edge where msg_valid && msg_ready.
  - Inputs are latched on that edge.
  - msg_ready drops the following cycle and stays low until the last stop bit completes.
- Length decode from the latched status:
  - 8n, 9n, An, Bn, En: 3 bytes.
  - Cn, Dn: 2 bytes.
  - F1, F3: 2 bytes.
  - F2: 3 bytes.
  - F0, F4-FF: 1 byte. Sysex bodies are sent as raw F0 then separate messages; this block adds nothing.
- Invalid status (bit7=0): accepted and dropped. status_err pulses the cycle after acceptance, nothing is sent, and msg_ready stays high.
- Sequencer FSM: IDLE -> START -> DATA -> STOP -> (next byte ? START : IDLE).
  - START drives 0 for DIV clocks.
  - DATA drives bits 0..7 for DIV clocks each, with a bit index of 0..7.
  - STOP drives 1 for DIV clocks; byte_done pulses on its last cycle.
- Timing:
  - midi_txd falls on the edge after acceptance, i.e. 1 cycle latency.
  - Consecutive bytes of a message follow with no idle gap, so frame length is 10*DIV.
  - A new message may be accepted the cycle after the final byte_done. Back-to-back messages therefore have no gap beyond the stop bit.
- busy = (state != IDLE).
- msg_valid while msg_ready=0 is ignored; the source must hold it.

Optional Feature:
- Macro: MIDI_RUNNING_STATUS_EN.
- With the macro defined, the block keeps last_status:
  - Channel messages (80-EF) whose status equals last_status omit the status byte and send data bytes only. Otherwise they send the status and update last_status.
  - F0-F7 send normally and clear last_status.
  - F8-FF send normally and leave last_status unchanged.
  - last_status is cleared on reset.
- Without the macro, every message transmits its status byte, and the last_status register is absent.

Decomposition:
- Package midi_pkg holds:
  - enum tx_state_t {IDLE, START, DATA, STOP}.
  - Status constants (NOTE_OFF=8'h80 … SYSTEM=8'hF0, RT_BASE=8'hF8).
  - Function msg_len(status) returning 0..3, where 0 means invalid.
- Sub-module midi_uart_tx, the byte-level 8N1 shifter:
  - byte_valid/byte_ready handshake in, midi_txd out.
  - Owns the divider and bit index.
- midi_tx_encoder sequences message bytes into it and owns running status.

Test Plan:
- Reset then idle 100 clocks -> midi_txd=1, msg_ready=1, busy=0 throughout.
- Send 90 3C 64 -> three frames.
  - Sampling at bit centres decodes 0x90, 0x3C, 0x64.
  - Start edge 1 cycle after acceptance; total 48000 clocks.
  - byte_done pulses at 16000, 32000 and 48000; then msg_ready=1.
- Send C5 07 (data2=FF) -> two frames 0xC5, 0x07, 32000 clocks. Data byte bit7 is sent as 0 when msg_data1=0x87.
- Send status 0x3C -> status_err pulse; midi_txd stays 1; msg_ready stays high.
- With MIDI_RUNNING_STATUS_EN, send 90 3C 64, then 90 3E 64, then F8, then 90 40 00:
  - Output bytes are 90 3C 64 3E 64 F8 40 00.
  - Without the macro, a 90 precedes every note message.
- Assert reset 5000 clocks into the 2nd frame of a 3-byte message:
  - midi_txd=1 within the same cycle; busy=0; msg_ready=1 after release.
  - A subsequent message transmits correctly from its start bit.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared MIDI definitions: serialiser state, status constants and the message length decode.
package midi_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam logic [7:0] NOTE_OFF    = 8'h80;
  localparam logic [7:0] NOTE_ON     = 8'h90;
  localparam logic [7:0] POLY_AT     = 8'hA0;
  localparam logic [7:0] CTRL_CHANGE = 8'hB0;
  localparam logic [7:0] PROG_CHANGE = 8'hC0;
  localparam logic [7:0] CHAN_AT     = 8'hD0;
  localparam logic [7:0] PITCH_BEND  = 8'hE0;
  localparam logic [7:0] SYSTEM      = 8'hF0;
  localparam logic [7:0] RT_BASE     = 8'hF8;

  // Total bytes in a message including its status; 0 flags a non-status byte.
  function automatic logic [1:0] msg_len(input logic [7:0] status);
    logic [1:0] len;
    len = 2'd1;
    if (!status[7]) begin
      len = 2'd0;
    end else begin
      case (status[7:4])
        4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd3;
        4'hC, 4'hD:                   len = 2'd2;
        default: begin
          case (status)
            8'hF1, 8'hF3: len = 2'd2;
            8'hF2:        len = 2'd3;
            default:      len = 2'd1;
          endcase
        end
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/midi_tx_encoder_if.sv
// Whole-message handshake between a MIDI message source and midi_tx_encoder.
interface midi_tx_encoder_if;
  logic       msg_valid;
  logic       msg_ready;
  logic [7:0] msg_status;
  logic [7:0] msg_data1;
  logic [7:0] msg_data2;

  modport master (output msg_valid, msg_status, msg_data1, msg_data2, input msg_ready);
  modport slave  (input msg_valid, msg_status, msg_data1, msg_data2, output msg_ready);
endinterface

// File: rtl/midi_uart_tx.sv
// Byte-level 8N1 serialiser, LSB first, idle high; accepts a new byte during the last stop cycle.
module midi_uart_tx
  import midi_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned BAUD      = 31250,
  parameter int unsigned BIT_CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       txd,
  output logic       byte_done
);

  localparam int unsigned DIV = CLK_HZ / BAUD;
  localparam logic [BIT_CNT_W-1:0] CntLast = BIT_CNT_W'(DIV - 1);
  localparam logic [BIT_CNT_W-1:0] CntDone = BIT_CNT_W'(DIV - 2);

  tx_state_t            state_q;
  logic [BIT_CNT_W-1:0] cnt_q;
  logic [2:0]           bit_idx_q;
  logic [7:0]           shreg_q;
  logic                 txd_q;
  logic                 byte_done_q;
  logic                 cnt_last;

  assign cnt_last   = (cnt_q == CntLast);
  assign byte_ready = (state_q == IDLE) || ((state_q == STOP) && cnt_last);
  assign txd        = txd_q;
  assign byte_done  = byte_done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      txd_q       <= 1'b1;
      byte_done_q <= 1'b0;
    end else begin
      byte_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (byte_valid) begin
            state_q <= START;
            shreg_q <= byte_data;
            cnt_q   <= '0;
            txd_q   <= 1'b0;
          end
        end
        START: begin
          if (cnt_last) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= DATA;
            txd_q     <= shreg_q[0];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_last) begin
            cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
              txd_q   <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              txd_q     <= shreg_q[1];
              shreg_q   <= {1'b0, shreg_q[7:1]};
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          // Registered one early so the pulse lands on the final stop cycle.
          if (cnt_q == CntDone) byte_done_q <= 1'b1;
          if (cnt_last) begin
            cnt_q <= '0;
            if (byte_valid) begin
              state_q <= START;
              shreg_q <= byte_data;
              txd_q   <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/midi_tx_encoder.sv
// MIDI message encoder: latches a whole message and feeds its bytes to the 8N1 serialiser.
// Optional running-status compression is built when MIDI_RUNNING_STATUS_EN is defined.
module midi_tx_encoder
  import midi_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned BAUD      = 31250,
  parameter int unsigned BIT_CNT_W = 16
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  midi_tx_encoder_if.slave  msg,
  output logic              midi_txd,
  output logic              busy,
  output logic              byte_done,
  output logic              status_err
);

  logic        msg_ready_q;
  logic        busy_q;
  logic        status_err_q;
  logic [1:0]  rem_q;
  logic [23:0] tx_buf_q;

  logic        accept;
  logic [1:0]  len;
  logic        skip_status;
  logic [23:0] load_buf;
  logic [1:0]  load_rem;
  logic        byte_valid;
  logic        byte_ready;
  logic        uart_done;

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0]  last_status_q;
`endif

  assign msg.msg_ready = msg_ready_q;
  assign busy          = busy_q;
  assign status_err    = status_err_q;
  assign byte_done     = uart_done;
  assign accept        = msg.msg_valid && msg_ready_q;
  assign byte_valid    = busy_q && (rem_q != 2'd0);

  always_comb begin
    len         = msg_len(msg.msg_status);
    skip_status = 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
    skip_status = (msg.msg_status >= NOTE_OFF) && (msg.msg_status < SYSTEM) &&
                  (msg.msg_status == last_status_q);
`endif
    if (skip_status) begin
      load_buf = {msg.msg_data1 & 8'h7F, msg.msg_data2 & 8'h7F, 8'h00};
      load_rem = len - 2'd1;
    end else begin
      load_buf = {msg.msg_status, msg.msg_data1 & 8'h7F, msg.msg_data2 & 8'h7F};
      load_rem = len;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      msg_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      status_err_q  <= 1'b0;
      rem_q         <= '0;
      tx_buf_q      <= '0;
`ifdef MIDI_RUNNING_STATUS_EN
      last_status_q <= '0;
`endif
    end else begin
      status_err_q <= 1'b0;
      if (accept) begin
        if (len == 2'd0) begin
          status_err_q <= 1'b1;
        end else begin
          msg_ready_q <= 1'b0;
          busy_q      <= 1'b1;
          tx_buf_q    <= load_buf;
          rem_q       <= load_rem;
`ifdef MIDI_RUNNING_STATUS_EN
          if (msg.msg_status < SYSTEM) begin
            last_status_q <= msg.msg_status;
          end else if (msg.msg_status < RT_BASE) begin
            last_status_q <= '0;
          end
`endif
        end
      end else if (busy_q) begin
        if (byte_valid && byte_ready) begin
          tx_buf_q <= {tx_buf_q[15:0], 8'h00};
          rem_q    <= rem_q - 2'd1;
        end
        // All bytes handed off and the last stop bit just finished.
        if ((rem_q == 2'd0) && uart_done) begin
          busy_q      <= 1'b0;
          msg_ready_q <= 1'b1;
        end
      end
    end
  end

  midi_uart_tx #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .BIT_CNT_W (BIT_CNT_W)
  ) u_uart (
    .clk        (CLOCK_50),
    .rst        (reset),
    .byte_valid (byte_valid),
    .byte_data  (tx_buf_q[23:16]),
    .byte_ready (byte_ready),
    .txd        (midi_txd),
    .byte_done  (uart_done)
  );

endmodule

// File: tb/tb_midi_tx_encoder.sv
// Bench for midi_tx_encoder: message-level timeline model, bit-centre UART decoder, directed messages.
module tb_midi_tx_encoder;

  localparam int unsigned CLK_HZ = 1000000;
  localparam int unsigned BAUD   = 31250;
  localparam int DIV   = CLK_HZ / BAUD;
  localparam int FRAME = 10 * DIV;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic midi_txd, busy, byte_done, status_err;

  midi_tx_encoder_if bus ();

  midi_tx_encoder #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .BIT_CNT_W (16)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .msg        (bus),
    .midi_txd   (midi_txd),
    .busy       (busy),
    .byte_done  (byte_done),
    .status_err (status_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- message-level model ----------------
  bit         m_active = 0;
  int         m_cnt = 0;
  logic [7:0] m_bytes[$];
  bit         m_err = 0;
  logic [7:0] m_last = 8'h00;
  bit         acc_flag = 0;

  task automatic model_accept(input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2);
    int len;
    logic [7:0] b[$];
    if (!s[7]) len = 0;
    else if ((s >= 8'h80 && s <= 8'hBF) || (s >= 8'hE0 && s <= 8'hEF) || s == 8'hF2) len = 3;
    else if ((s >= 8'hC0 && s <= 8'hDF) || s == 8'hF1 || s == 8'hF3) len = 2;
    else len = 1;
    if (len == 0) begin
      m_err = 1;
      return;
    end
    b.push_back(s);
    if (len > 1) b.push_back(d1 & 8'h7F);
    if (len > 2) b.push_back(d2 & 8'h7F);
`ifdef MIDI_RUNNING_STATUS_EN
    if (s < 8'hF0) begin
      if (s == m_last) void'(b.pop_front());
      m_last = s;
    end else if (s < 8'hF8) begin
      m_last = 8'h00;
    end
`endif
    m_bytes  = b;
    m_cnt    = 0;
    m_active = 1;
  endtask

  always @(posedge clk) begin
    bit was_ready;
    if (reset) begin
      m_active = 0;
      m_cnt    = 0;
      m_err    = 0;
      m_last   = 8'h00;
      m_bytes.delete();
    end else begin
      was_ready = !m_active;
      m_err = 0;
      if (m_active) begin
        m_cnt++;
        if (m_cnt > FRAME * m_bytes.size()) m_active = 0;
      end
      if (was_ready && bus.msg_valid) begin
        model_accept(bus.msg_status, bus.msg_data1, bus.msg_data2);
        acc_flag = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int done_q[$];
  int err_cnt   = 0;
  int first_low = -1;

  always @(negedge clk) begin
    logic e_txd, e_done, e_busy, e_ready;
    int pos, f, b;
    if (!reset) begin
      e_txd = 1'b1; e_done = 1'b0; e_busy = 1'b0; e_ready = 1'b1;
      if (m_active) begin
        e_busy  = 1'b1;
        e_ready = 1'b0;
        if (m_cnt > 0) begin
          pos = (m_cnt - 1) % FRAME;
          f   = (m_cnt - 1) / FRAME;
          b   = pos / DIV;
          if (b == 0) e_txd = 1'b0;
          else if (b <= 8) e_txd = m_bytes[f][b-1];
          e_done = (pos == FRAME - 1);
        end
      end
      chk("txd", midi_txd, e_txd);
      chk("byte_done", byte_done, e_done);
      chk("busy", busy, e_busy);
      chk("msg_ready", bus.msg_ready, e_ready);
      chk("status_err", status_err, m_err);
      if (byte_done) done_q.push_back(m_cnt);
      if (status_err) err_cnt++;
      if (m_active && midi_txd == 1'b0 && first_low < 0) first_low = m_cnt;
    end
  end

  // ---------------- bit-centre UART decoder ----------------
  int         rx_state = 0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = 8'h00;
  logic [7:0] rx_q[$];

  always @(negedge clk) begin
    int b;
    if (reset) begin
      rx_state = 0;
    end else if (rx_state == 0) begin
      if (midi_txd == 1'b0) begin
        rx_state = 1;
        rx_cnt   = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % DIV == DIV / 2) begin
        b = rx_cnt / DIV;
        if (b == 0) begin
          if (midi_txd != 1'b0) rx_state = 0;
        end else if (b <= 8) begin
          rx_sh[b-1] = midi_txd;
        end else begin
          chk("rx_stop_bit", midi_txd, 1'b1);
          rx_q.push_back(rx_sh);
          rx_state = 0;
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  logic [7:0] exp_q[$];

  task automatic check_rx(input string name);
    chk({name, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s_byte%0d", name, i), (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hDEAD,
          exp_q[i]);
    end
  endtask

  task automatic send(input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2);
    @(negedge clk);
    bus.msg_status = s;
    bus.msg_data1  = d1;
    bus.msg_data2  = d2;
    bus.msg_valid  = 1'b1;
    acc_flag  = 0;
    first_low = -1;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (acc_flag) break;
    end
    bus.msg_valid = 1'b0;
    chk("accept_in_time", acc_flag, 1'b1);
    acc_flag = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (!m_active) break;
    end
    chk("idle_in_time", m_active, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.msg_valid  = 1'b0;
    bus.msg_status = 8'h00;
    bus.msg_data1  = 8'h00;
    bus.msg_data2  = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_txd", midi_txd, 1'b1);
    chk("rst_ready", bus.msg_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", byte_done, 1'b0);
    chk("rst_err", status_err, 1'b0);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    chk("idle_txd", midi_txd, 1'b1);

    // Note on: three frames, start bit one cycle after acceptance.
    rx_q.delete(); done_q.delete();
    send(8'h90, 8'h3C, 8'h64);
    wait_idle();
    exp_q = '{8'h90, 8'h3C, 8'h64};
    check_rx("note_on");
    chk("first_low_cycle", first_low, 1);
    chk("done_count", done_q.size(), 3);
    chk("done0", (done_q.size() > 0) ? done_q[0] : -1, 320);
    chk("done1", (done_q.size() > 1) ? done_q[1] : -1, 640);
    chk("done2", (done_q.size() > 2) ? done_q[2] : -1, 960);

    // Program change: two frames, data bit7 forced to 0.
    rx_q.delete(); done_q.delete();
    send(8'hC5, 8'h87, 8'hFF);
    wait_idle();
    exp_q = '{8'hC5, 8'h07};
    check_rx("prog_change");
    chk("pc_last_done", (done_q.size() > 1) ? done_q[1] : -1, 640);

    // Invalid status: dropped with an error pulse.
    rx_q.delete(); err_cnt = 0;
    send(8'h3C, 8'h11, 8'h22);
    repeat (5) @(negedge clk);
    chk("invalid_err_pulses", err_cnt, 1);
    chk("invalid_no_bytes", rx_q.size(), 0);
    chk("invalid_ready", bus.msg_ready, 1'b1);
    chk("invalid_txd", midi_txd, 1'b1);

    // Running-status sequence.
    rx_q.delete();
    send(8'h90, 8'h3C, 8'h64); wait_idle();
    send(8'h90, 8'h3E, 8'h64); wait_idle();
    send(8'hF8, 8'h00, 8'h00); wait_idle();
    send(8'h90, 8'h40, 8'h00); wait_idle();
`ifdef MIDI_RUNNING_STATUS_EN
    exp_q = '{8'h90, 8'h3C, 8'h64, 8'h3E, 8'h64, 8'hF8, 8'h40, 8'h00};
`else
    exp_q = '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3E, 8'h64, 8'hF8, 8'h90, 8'h40, 8'h00};
`endif
    check_rx("running");

    // Reset mid-way through the second frame of a 3-byte message.
    send(8'hA0, 8'h10, 8'h20);
    for (int i = 0; i < 20000; i++) begin
      if (m_cnt == FRAME + 100) break;
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    chk("midrst_txd", midi_txd, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", bus.msg_ready, 1'b1);
    rx_q.delete();
    send(8'h80, 8'h40, 8'h7F);
    wait_idle();
    exp_q = '{8'h80, 8'h40, 8'h7F};
    check_rx("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
